// File: rtl/ime_sad_sched.sv
// Round-robin scheduler and row sequencer for the shared 16-lane IME abs-diff datapath.
// Optional early termination on threshold is enabled by defining IME_SAD_EARLY_TERM_EN.
module ime_sad_sched #(
  parameter int ADDR_W    = 8,
  parameter int SAD_W     = 16,
  parameter int BIT_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_i,
  input  logic [ADDR_W-1:0]         ref_base0_i,
  input  logic [ADDR_W-1:0]         ref_base1_i,
  input  logic [SAD_W-1:0]          thr_i,
  output logic [1:0]                ack_o,
  output logic                      rd_en_o,
  output logic [3:0]                cur_addr_o,
  output logic [ADDR_W-1:0]         ref_addr_o,
  input  logic [16*BIT_DEPTH-1:0]   cur_row_i,
  input  logic [16*BIT_DEPTH-1:0]   ref_row_i,
  output logic                      sad_valid_o,
  output logic [SAD_W-1:0]          sad_o,
  output logic                      sad_id_o,
  output logic                      early_o
);

  localparam int RS_W = BIT_DEPTH + 4;

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_id;
  logic              cur_id;
  logic              grant_id;
  logic [ADDR_W-1:0] base_r;
  logic [3:0]        row;
  logic [SAD_W-1:0]  acc;
  logic [RS_W-1:0]   rsum;
  logic              vld_p0;
  logic              early_r;
  logic              stop;
  logic [1:0]        ack_r;

  function automatic logic [BIT_DEPTH-1:0] abs_diff(input logic [BIT_DEPTH-1:0] a,
                                                    input logic [BIT_DEPTH-1:0] b);
    logic signed [BIT_DEPTH:0] d;
    logic signed [BIT_DEPTH:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = d[BIT_DEPTH] ? -d : d;
    return m[BIT_DEPTH-1:0];
  endfunction

  // Pairwise reduction in place: slot i at each level consumes slots 2i and 2i+1.
  function automatic logic [RS_W-1:0] row_sum(input logic [16*BIT_DEPTH-1:0] c,
                                               input logic [16*BIT_DEPTH-1:0] r);
    logic [RS_W-1:0] t [16];
    for (int i = 0; i < 16; i++)
      t[i] = RS_W'(abs_diff(c[i*BIT_DEPTH +: BIT_DEPTH], r[i*BIT_DEPTH +: BIT_DEPTH]));
    for (int s = 8; s >= 1; s = s / 2)
      for (int i = 0; i < s; i++)
        t[i] = t[2*i] + t[2*i+1];
    return t[0];
  endfunction

  // On a tie the requester not served last wins.
  assign grant_id = (req_i == 2'b11) ? ~last_id : req_i[1];

`ifdef IME_SAD_EARLY_TERM_EN
  logic [SAD_W-1:0] thr_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      thr_r <= '0;
    else if (state == IDLE && |req_i)
      thr_r <= thr_i;
  end

  assign stop = (state == READ) && (acc > thr_r);
`else
  logic unused_thr;
  assign unused_thr = ^thr_i;
  assign stop       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rd_en_o     = 1'b0;
    sad_valid_o = 1'b0;
    case (state)
      IDLE: if (|req_i) state_nxt = READ;
      READ: begin
        if (stop) begin
          state_nxt = DONE;
        end else begin
          rd_en_o = 1'b1;
          if (row == 4'd15) state_nxt = WAIT;
        end
      end
      WAIT: state_nxt = DONE;
      DONE: begin
        sad_valid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= 4'd0;
      base_r  <= '0;
      cur_id  <= 1'b0;
      last_id <= 1'b1;
      early_r <= 1'b0;
      ack_r   <= 2'b00;
    end else begin
      ack_r <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_i) begin
            cur_id  <= grant_id;
            base_r  <= grant_id ? ref_base1_i : ref_base0_i;
            ack_r   <= grant_id ? 2'b10 : 2'b01;
            row     <= 4'd0;
            early_r <= 1'b0;
          end
        end
        READ: begin
          if (stop) early_r <= 1'b1;
          else      row     <= row + 4'd1;
        end
        DONE:    last_id <= cur_id;
        default: ;
      endcase
    end
  end

  // Stage p0: read data returns one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= rd_en_o;
  end

  assign rsum = row_sum(cur_row_i, ref_row_i);

  // A row landing in the cycle that triggers the stop is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (state == IDLE && |req_i)
      acc <= '0;
    else if (vld_p0 && !stop)
      acc <= acc + SAD_W'(rsum);
  end

  assign ack_o      = ack_r;
  assign cur_addr_o = rd_en_o ? row : 4'd0;
  assign ref_addr_o = rd_en_o ? (base_r + ADDR_W'(row)) : '0;
  assign sad_o      = sad_valid_o ? acc : '0;
  assign sad_id_o   = sad_valid_o & cur_id;
  assign early_o    = sad_valid_o & early_r;

endmodule

// File: doc/ime_sad_sched.md
# ime_sad_sched

Round-robin scheduler and sequencer for the shared integer-ME absolute-difference row datapath. Two search requesters share one row of 16 `BIT_DEPTH`-wide abs-diff units. The block grants one requester at a time and walks 16 rows of a 16x16 block through current and reference pixel memories. It accumulates the per-row sums of absolute differences and returns a tagged SAD per request. It sits between the IME candidate generators and the current/reference pixel buffers.

## Interface
- `ADDR_W`, 8: reference row address width.
- `SAD_W`, 16: SAD accumulator and output width. Must be at least `BIT_DEPTH`+8.
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_i`, in, 2: per-requester request level. Held high until the matching `ack_o` bit.
- `ref_base0_i`, in, `ADDR_W`: reference base row for requester 0. Sampled at grant.
- `ref_base1_i`, in, `ADDR_W`: reference base row for requester 1. Sampled at grant.
- `thr_i`, in, `SAD_W`: early-termination threshold. Sampled at grant.
- `ack_o`, out, 2: one-hot, single-cycle grant pulse.
- `rd_en_o`, out, 1: pixel memory read strobe.
- `cur_addr_o`, out, 4: current block row index, 0..15.
- `ref_addr_o`, out, `ADDR_W`: latched base plus row index, modulo 2^`ADDR_W`.
- `cur_row_i`, in, 16*`BIT_DEPTH`: current row. Valid the cycle after `rd_en_o`.
- `ref_row_i`, in, 16*`BIT_DEPTH`: reference row. Valid the cycle after `rd_en_o`.
- `sad_valid_o`, out, 1: single-cycle result strobe.
- `sad_o`, out, `SAD_W`: accumulated SAD.
- `sad_id_o`, out, 1: index of the requester that owns the result.
- `early_o`, out, 1: result was produced by early termination.

## Operation
- FSM states: IDLE, READ, WAIT, DONE.
- IDLE:
  - If any `req_i` bit is set, grant one requester by round-robin.
  - The last-granted pointer resets to 1, so requester 0 wins the first tie.
  - At grant: latch the id, its base and `thr_i`; clear the accumulator and row counter; go to READ.
- READ:
  - Assert `rd_en_o` and drive `cur_addr_o` = row and `ref_addr_o` = base+row.
  - Row counter runs 0..15. After row 15 issues, go to WAIT.
- Data path:
  - Each data cycle, compute 16 absolute differences |cur−ref| on unsigned `BIT_DEPTH` values, zero-extended with a borrow check.
  - Sum them with an adder tree to a `BIT_DEPTH`+4 row sum, then add into the accumulator.
  - No saturation is needed: the maximum 16*16*255 = 65280 fits in 16 bits.
- WAIT: absorbs the final row's data, then goes to DONE.
- DONE:
  - Pulse `sad_valid_o` with `sad_o`, `sad_id_o` and `early_o`.
  - Update the round-robin pointer to the served id and return to IDLE.
- `req_i` changes outside IDLE are ignored. A request is never dropped; it stays pending.

## Timing
- Cycle 0: IDLE samples `req_i`.
- Cycle 1: `ack_o` pulse; first READ cycle with row 0.
- Cycles 1..16: `rd_en_o`=1 for rows 0..15.
- Cycles 2..17: row data arrives and is accumulated at the end of each cycle. Cycle 17 is WAIT.
- Cycle 18: DONE, `sad_valid_o`=1.
- Cycle 19: IDLE. The earliest next grant sample is cycle 19, so back-to-back throughput is 19 cycles per SAD.
- Both requesters high at cycle 0: the grant goes to the requester not served last. The other is granted at cycle 19 if it is still requesting.
- Reset values: all outputs 0, FSM IDLE, accumulator 0, round-robin pointer 1.
- `rst_n` low mid-operation: abort immediately. No `sad_valid_o` is issued; the requester must re-request.
- `ref_addr_o` wraps modulo 2^`ADDR_W`. Example: base 8'hF8 with row 10 gives 8'h02.

## Configuration
- `IME_SAD_EARLY_TERM_EN` defined:
  - While in READ, if the registered accumulator is greater than the latched threshold, the next state is DONE.
  - `rd_en_o` drops that cycle, and the in-flight row is discarded.
  - DONE reports the accumulator value that triggered the stop, with `early_o`=1.
  - A threshold equal to the accumulator does not terminate.
- `IME_SAD_EARLY_TERM_EN` undefined:
  - `thr_i` is ignored, `early_o` is tied to 0, and every request runs all 16 rows.
  - Ports are identical in both builds.

## Test plan
- Single request: req0, base 8'h10, all cur=200, all ref=190 → `ack_o`=01 at cycle 1; `ref_addr_o` runs 0x10..0x1F; at cycle 18 `sad_o`=2560, `sad_id_o`=0, `early_o`=0.
- Reversed operands: cur=0, ref=255 on every row → `sad_o`=65280, showing no overflow and a correct abs for the negative difference.
- Arbitration: req_i=11 held → grants in order 0, 1, 0. The second `ack_o` comes 19 cycles after the first. The `sad_id_o` sequence is 0, 1, 0.
- Address wrap: base 8'hF8 → the row 10 address is 8'h02.
- Reset at cycle 8 of an operation → all outputs 0 and no `sad_valid_o`; the next request completes normally with the full-latency SAD.
- With `IME_SAD_EARLY_TERM_EN`: thr=500, per-row sum 160.
  - After rows 0..3 the accumulator is 640, which exceeds the threshold.
  - Result: `early_o`=1 and `sad_o`=640, strobed before cycle 18.
  - thr=2560 with the same data runs all 16 rows and reports `early_o`=0.
